approx_max_stream: RTL and testbench

Streaming, parametrised successor to the combinational approximate-max blocks. It accepts a valid/ready stream of unsigned WIDTH-bit operands grouped into frames and finds the maximum of each frame. Each result carries the winning operand's index, the frame length and a truncation flag. A per-frame approximation mode ignores and zeroes the DROP least-significant bits, equivalent to the tied-off low output bit of the factorised circuits. It sits between an operand producer and a result consumer in the approximate-datapath benches.

---
 rtl/approx_max_stream.sv | 131 +++++++++++++
 tb/tb_approx_max_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_max_stream.sv
// approx_max_stream: streaming frame maximum finder.
// Accepts a valid/ready stream of unsigned operands grouped into frames and
// reports the maximum, its 0-based beat index, the frame length and whether
// the frame was closed by MAX_LEN instead of in_last. An optional per-frame
// approximate mode clears the DROP low bits before compare and storage.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// and out_valid depend on registered state only, and out_valid/out_* stay
// stable until the result transfers.
module approx_max_stream #(
    parameter int WIDTH   = 8,
    parameter int DROP    = 1,
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             approx_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_len,
    output logic             out_trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Mask that clears the DROP low bits; all ones when DROP is 0.
    localparam logic [WIDTH-1:0] MASK    = {WIDTH{1'b1}} << DROP;
    localparam logic [IDX_W:0]   LEN_CAP = (IDX_W + 1)'(MAX_LEN);

    state_t           state;
    logic             mode;
    logic [WIDTH-1:0] max_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   cnt_q;

    logic             beat;
    logic             first;
    logic             cur_mode;
    logic [WIDTH-1:0] masked;
    logic             bigger;
    logic [WIDTH-1:0] nxt_max;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W:0]   nxt_cnt;
    logic             at_cap;
    logic             close;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign beat      = in_valid && in_ready;

    // Running max update for the beat currently on the input.
    always_comb begin
        first    = (state == IDLE);
        cur_mode = first ? approx_en : mode;
        masked   = cur_mode ? (in_data & MASK) : in_data;
        // Strict compare keeps the earliest index on ties.
        bigger   = masked > max_q;
        nxt_max  = max_q;
        nxt_idx  = idx_q;
        nxt_cnt  = cnt_q + 1'b1;
        if (first) begin
            nxt_max = masked;
            nxt_idx = '0;
            nxt_cnt = (IDX_W + 1)'(1);
        end else if (bigger) begin
            nxt_max = masked;
            nxt_idx = cnt_q[IDX_W-1:0];
        end
        // MAX_LEN >= 2, so a first beat never reaches the cap.
        at_cap = (nxt_cnt == LEN_CAP);
        close  = in_last || at_cap;
    end

    // Frame FSM, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= 1'b0;
            max_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            out_len   <= '0;
            out_trunc <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat) begin
                        if (state == IDLE) begin
                            mode <= approx_en;
                        end
                        max_q <= nxt_max;
                        idx_q <= nxt_idx;
                        cnt_q <= nxt_cnt;
                        if (close) begin
                            state     <= HOLD;
                            out_max   <= nxt_max;
                            out_idx   <= nxt_idx;
                            out_len   <= nxt_cnt;
                            out_trunc <= !in_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_max_stream.sv
// Testbench for approx_max_stream with WIDTH=8, DROP=2, MAX_LEN=4.
// Directed scenarios followed by random frames, all checked against a
// frame-level reference model held in the bench.
module tb_approx_max_stream;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int ML = 4;
  localparam int IW = 2;

  // Packed expected result: {max[13:6], idx[5:4], len[3:1], trunc[0]}
  localparam int RW = W + IW + IW + 1 + 1;

  logic          clk;
  logic          rst;
  logic          approx_en;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_len;
  logic          out_trunc;

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0] exp_q[$];
  logic [W-1:0]  cur_beats[$];
  logic          cur_mode;

  approx_max_stream #(
    .WIDTH(W), .DROP(D), .MAX_LEN(ML), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .approx_en(approx_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_len(out_len), .out_trunc(out_trunc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: max over masked beats, first index of that max
  function automatic logic [RW-1:0] ref_result(input logic [W-1:0] b[$], input logic m,
                                               input logic tr);
    logic [W-1:0] mask;
    logic [W-1:0] best;
    logic [W-1:0] v;
    int bi;
    mask = ~((8'd1 << D) - 8'd1);
    best = '0;
    bi   = 0;
    foreach (b[i]) begin
      v = m ? (b[i] & mask) : b[i];
      if (i == 0 || v > best) begin
        best = v;
        bi   = i;
      end
    end
    return {best, IW'(bi), (IW + 1)'(b.size()), tr};
  endfunction

  // framing rule: mode from the first beat, close on last or at ML beats
  task automatic model_beat(input logic [W-1:0] d, input logic l, input logic a);
    if (cur_beats.size() == 0) cur_mode = a;
    cur_beats.push_back(d);
    if (l || cur_beats.size() == ML) begin
      exp_q.push_back(ref_result(cur_beats, cur_mode, !l));
      cur_beats.delete();
    end
  endtask

  // driver: entered and left at a falling edge
  task automatic put_beat(input logic [W-1:0] d, input logic l, input logic a);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = l;
    approx_en = a;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      model_beat(d, l, a);
    end
  endtask

  task automatic check_fields(input string tag, input logic [RW-1:0] e);
    chk({tag, "_max"},   out_max,   e[13:6]);
    chk({tag, "_idx"},   out_idx,   e[5:4]);
    chk({tag, "_len"},   out_len,   e[3:1]);
    chk({tag, "_trunc"}, out_trunc, e[0]);
  endtask

  // scoreboard: wait for result, hold it for some cycles, then hand it off
  task automatic check_result(input int hold_cycles);
    logic [RW-1:0] e;
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("out_valid", out_valid, 1);
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL exp_q observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i <= hold_cycles; i++) begin
        chk("hold_in_ready", in_ready, 0);
        chk("hold_out_valid", out_valid, 1);
        check_fields("hold", e);
        if (i < hold_cycles) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      check_fields("post", e);
    end
  endtask

  initial begin
    logic [RW-1:0] e;
    int n;
    logic lst;
    rst       = 1'b1;
    approx_en = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    cur_mode  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    check_fields("rst", '0);

    // exact frame, result visible right after the closing beat
    put_beat(8'h12, 1'b0, 1'b0);
    put_beat(8'h7F, 1'b0, 1'b0);
    put_beat(8'h30, 1'b1, 1'b0);
    chk("exact_latency", out_valid, 1);
    check_result(0);

    // approximate tie, mode change on second beat ignored
    put_beat(8'h41, 1'b0, 1'b1);
    put_beat(8'h43, 1'b1, 1'b0);
    check_result(1);

    // truncation with backpressure; beat 9 waits through HOLD
    put_beat(8'd1, 1'b0, 1'b0);
    put_beat(8'd2, 1'b0, 1'b0);
    put_beat(8'd3, 1'b0, 1'b0);
    put_beat(8'd4, 1'b0, 1'b0);
    e = exp_q.pop_front();
    in_valid  = 1'b1;
    in_data   = 8'd9;
    in_last   = 1'b1;
    approx_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("trunc_in_ready", in_ready, 0);
      chk("trunc_out_valid", out_valid, 1);
      check_fields("trunc", e);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("trunc_post_valid", out_valid, 0);
    chk("trunc_post_ready", in_ready, 1);
    check_fields("trunc_post", e);
    @(negedge clk);
    in_valid = 1'b0;
    model_beat(8'd9, 1'b1, 1'b0);
    check_result(2);

    // reset mid-frame discards the partial frame
    put_beat(8'hAA, 1'b0, 1'b0);
    put_beat(8'hBB, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_beats.delete();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    check_fields("midrst", '0);
    put_beat(8'h05, 1'b1, 1'b0);
    check_result(0);

    // single-beat approximate frame
    put_beat(8'hFF, 1'b1, 1'b1);
    check_result(0);

    // random frames with input gaps, mid-frame mode toggles and backpressure
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, ML);
      for (int b = 0; b < n; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        lst = (b == n - 1) ? ((n < ML) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
        put_beat(W'($urandom_range(0, 255)), lst, 1'($urandom_range(0, 1)));
      end
      check_result($urandom_range(0, 3));
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
